sa_share_division: RTL and testbench

- Iterative signed divider that consumes the SA top level's division request and returns the quotient it waits on.
- The SA data path drives dividend, dividor and division_start. This block returns signed_division and a one-cycle division_done.
- Sits directly downstream of the SA top level, one instance per SA core.
- Restoring algorithm, one quotient bit per clock, no multiplier.

---
 rtl/sa_share_division.sv | 187 ++++++++++++++++++
 tb/tb_sa_share_division.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_share_division.sv
// ---------------------------------------------------------------------------
// sa_share_division
//
// Iterative signed divider serving one SA core. A request is accepted only
// while idle; the operands are converted to magnitudes and divided with a
// restoring algorithm that produces one quotient bit per clock. The sign is
// applied afterwards, and the result is saturated to the quotient width.
// The quotient truncates toward zero.
//
// Ports:
//   CLK             in   rising-edge clock
//   RST             in   synchronous active-high reset
//   dividend        in   signed numerator, sampled on an accepted start
//   dividor         in   signed denominator, sampled on an accepted start
//   division_start  in   request (level or pulse), accepted only when idle
//   signed_division out  signed saturated quotient, held until next result
//   division_done   out  one-cycle pulse marking a new result
//   div_busy        out  high from acceptance until division_done
//   div_zero        out  divisor was zero for the held result
// ---------------------------------------------------------------------------
module sa_share_division #(
    parameter int DIVIDEND_WIDTH = 12,
    parameter int DIVIDOR_WIDTH  = 12,
    parameter int QUOTIENT_WIDTH = 9
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVIDOR_WIDTH-1:0]  dividor,
    input  logic                      division_start,
    output logic [QUOTIENT_WIDTH-1:0] signed_division,
    output logic                      division_done,
    output logic                      div_busy,
    output logic                      div_zero
);

    localparam int CW = (DIVIDEND_WIDTH > 1) ? $clog2(DIVIDEND_WIDTH) : 1;
    localparam int EW = ((DIVIDEND_WIDTH > QUOTIENT_WIDTH) ? DIVIDEND_WIDTH : QUOTIENT_WIDTH) + 1;

    localparam logic [EW-1:0] POS_LIMIT = EW'((1 << (QUOTIENT_WIDTH - 1)) - 1);
    localparam logic [EW-1:0] NEG_LIMIT = EW'(1 << (QUOTIENT_WIDTH - 1));
    localparam logic [QUOTIENT_WIDTH-1:0] Q_MAX = {1'b0, {(QUOTIENT_WIDTH-1){1'b1}}};
    localparam logic [QUOTIENT_WIDTH-1:0] Q_MIN = {1'b1, {(QUOTIENT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CW-1:0]             bit_cnt;
    // Holds the numerator magnitude; quotient bits shift in from the bottom
    // as numerator bits shift out of the top, so it ends up as the quotient.
    logic [DIVIDEND_WIDTH-1:0] num_q;
    logic [DIVIDOR_WIDTH-1:0]  den_q;
    logic [DIVIDOR_WIDTH:0]    rem_q;
    logic                      sign_q;
    logic                      sign_n;
    logic                      zero_q;

    logic [DIVIDEND_WIDTH-1:0] dividend_mag;
    logic [DIVIDOR_WIDTH-1:0]  dividor_mag;
    logic [DIVIDOR_WIDTH+1:0]  trial;
    logic [DIVIDOR_WIDTH+1:0]  den_ext;
    logic                      trial_ge;
    logic [EW-1:0]             q_ext;
    logic [QUOTIENT_WIDTH-1:0] fixed_q;

    // Operand magnitudes. The most negative value negates onto itself, which
    // read as unsigned is exactly its magnitude, so no extra bit is needed.
    always_comb begin
        dividend_mag = dividend[DIVIDEND_WIDTH-1] ? -dividend : dividend;
        dividor_mag  = dividor[DIVIDOR_WIDTH-1]   ? -dividor  : dividor;
    end

    // One restoring step: bring down the next numerator bit and test whether
    // the divisor fits into the partial remainder.
    always_comb begin
        trial    = {rem_q, num_q[DIVIDEND_WIDTH-1]};
        den_ext  = {2'b00, den_q};
        trial_ge = (trial >= den_ext);
    end

    // Sign application and saturation of the unsigned quotient. A zero
    // divisor saturates in the direction of the numerator's sign.
    always_comb begin
        q_ext = EW'(num_q);
        if (zero_q) begin
            fixed_q = sign_n ? Q_MIN : Q_MAX;
        end else if (sign_q) begin
            fixed_q = (q_ext > NEG_LIMIT) ? Q_MIN : QUOTIENT_WIDTH'(-q_ext);
        end else begin
            fixed_q = (q_ext > POS_LIMIT) ? Q_MAX : QUOTIENT_WIDTH'(q_ext);
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and the status outputs, which depend only on the state.
    always_comb begin
        state_d       = state_q;
        div_busy      = 1'b0;
        division_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (division_start) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                div_busy = 1'b1;
                if (bit_cnt == CW'(DIVIDEND_WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                div_busy = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                division_done = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath registers: operand capture, iteration and result update.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_cnt         <= '0;
            num_q           <= '0;
            den_q           <= '0;
            rem_q           <= '0;
            sign_q          <= 1'b0;
            sign_n          <= 1'b0;
            zero_q          <= 1'b0;
            signed_division <= '0;
            div_zero        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (division_start) begin
                        bit_cnt <= '0;
                        num_q   <= dividend_mag;
                        den_q   <= dividor_mag;
                        rem_q   <= '0;
                        sign_q  <= dividend[DIVIDEND_WIDTH-1] ^ dividor[DIVIDOR_WIDTH-1];
                        sign_n  <= dividend[DIVIDEND_WIDTH-1];
                        zero_q  <= (dividor == '0);
                    end
                end
                CALC: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    num_q   <= {num_q[DIVIDEND_WIDTH-2:0], trial_ge};
                    // The restored remainder is always below the divisor, so
                    // dropping the top trial bit loses nothing.
                    if (trial_ge) begin
                        rem_q <= (DIVIDOR_WIDTH+1)'(trial - den_ext);
                    end else begin
                        rem_q <= (DIVIDOR_WIDTH+1)'(trial);
                    end
                end
                FIX: begin
                    signed_division <= fixed_q;
                    div_zero        <= zero_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sa_share_division.sv
// ---------------------------------------------------------------------------
// tb_sa_share_division
//
// Self-checking bench for sa_share_division. Expected quotients come from a
// plain integer model (truncating division, clamp to the quotient range,
// divide-by-zero saturating by numerator sign). Each scenario task drives
// stimulus and compares outputs cycle by cycle, sampling 1 time unit after
// each rising edge. Cycle c means the interval following rising edge c,
// where the start request is driven during cycle 0.
// ---------------------------------------------------------------------------
module tb_sa_share_division;

    localparam int DW  = 12;
    localparam int DVW = 12;
    localparam int QW  = 9;
    localparam int LAT = DW + 2;
    localparam int QMAX = (1 << (QW - 1)) - 1;
    localparam int QMIN = -(1 << (QW - 1));

    logic          CLK;
    logic          RST;
    logic [DW-1:0] dividend;
    logic [DVW-1:0] dividor;
    logic          division_start;
    logic [QW-1:0] signed_division;
    logic          division_done;
    logic          div_busy;
    logic          div_zero;

    int n_checks;
    int n_errors;

    logic [QW-1:0] prev_q;
    logic          prev_z;

    sa_share_division #(
        .DIVIDEND_WIDTH (DW),
        .DIVIDOR_WIDTH  (DVW),
        .QUOTIENT_WIDTH (QW)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .dividend        (dividend),
        .dividor         (dividor),
        .division_start  (division_start),
        .signed_division (signed_division),
        .division_done   (division_done),
        .div_busy        (div_busy),
        .div_zero        (div_zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: integer division truncates toward zero, then clamp.
    function automatic void model(input int a, input int b, output logic [QW-1:0] q, output logic z);
        int r;
        if (b == 0) begin
            r = (a < 0) ? QMIN : QMAX;
            z = 1'b1;
        end else begin
            r = a / b;
            if (r > QMAX) r = QMAX;
            if (r < QMIN) r = QMIN;
            z = 1'b0;
        end
        q = QW'(r);
    endfunction

    // One complete operation started with a single-cycle pulse; operands are
    // scrambled right after acceptance to show they are not re-sampled.
    task automatic run_div(input int a, input int b, input string tag);
        logic [QW-1:0] eq;
        logic          ez;
        logic [QW-1:0] want_q;
        logic          want_z;
        model(a, b, eq, ez);
        @(posedge CLK); #1;
        dividend       = DW'(a);
        dividor        = DVW'(b);
        division_start = 1'b1;
        for (int c = 1; c <= LAT + 1; c++) begin
            @(posedge CLK); #1;
            if (c == 1) begin
                division_start = 1'b0;
                dividend       = DW'($urandom);
                dividor        = DVW'($urandom);
            end
            n_checks++;
            if (div_busy !== (c < LAT)) begin
                n_errors++;
                $display("[TB] FAIL %s busy cycle %0d: got %b expected %b", tag, c, div_busy, (c < LAT));
            end
            n_checks++;
            if (division_done !== (c == LAT)) begin
                n_errors++;
                $display("[TB] FAIL %s done cycle %0d: got %b expected %b", tag, c, division_done, (c == LAT));
            end
            if (c >= LAT - 1) begin
                want_q = (c >= LAT) ? eq : prev_q;
                want_z = (c >= LAT) ? ez : prev_z;
                n_checks++;
                if (signed_division !== want_q) begin
                    n_errors++;
                    $display("[TB] FAIL %s quotient cycle %0d (%0d/%0d): got %h expected %h", tag, c, a, b, signed_division, want_q);
                end
                n_checks++;
                if (div_zero !== want_z) begin
                    n_errors++;
                    $display("[TB] FAIL %s div_zero cycle %0d (%0d/%0d): got %b expected %b", tag, c, a, b, div_zero, want_z);
                end
            end
        end
        prev_q = eq;
        prev_z = ez;
    endtask

    task automatic test_reset();
        RST            = 1'b1;
        division_start = 1'b0;
        dividend       = '0;
        dividor        = '0;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if ({signed_division, division_done, div_busy, div_zero} !== '0) begin
            n_errors++;
            $display("[TB] FAIL reset_state: got q=%h done=%b busy=%b zero=%b expected all zero", signed_division, division_done, div_busy, div_zero);
        end
        RST    = 1'b0;
        prev_q = '0;
        prev_z = 1'b0;
    endtask

    task automatic test_basic();
        run_div(100, 7, "basic_100_7");
    endtask

    task automatic test_signs();
        int ta[5] = '{-100, 100, -100, -7, 3};
        int tb[5] = '{7, -7, -7, 2, 5};
        for (int i = 0; i < 5; i++) run_div(ta[i], tb[i], "sign");
    endtask

    task automatic test_saturation();
        int ta[5] = '{2000, -2000, -2048, 255, -256};
        int tb[5] = '{3, 3, -1, 1, 1};
        for (int i = 0; i < 5; i++) run_div(ta[i], tb[i], "saturate");
    endtask

    task automatic test_div_zero();
        run_div(5, 0, "zero_pos");
        run_div(-5, 0, "zero_neg");
        run_div(0, 0, "zero_zero");
        run_div(6, 3, "after_zero");
    endtask

    task automatic test_random();
        int a;
        int b;
        for (int i = 0; i < 24; i++) begin
            a = int'($urandom_range(0, 4095)) - 2048;
            case ($urandom_range(0, 7))
                0:       b = 0;
                1, 2, 3: b = int'($urandom_range(0, 40)) - 20;
                default: b = int'($urandom_range(0, 4095)) - 2048;
            endcase
            run_div(a, b, "random");
        end
    endtask

    // A second pulse mid-operation, with new operands, must be ignored.
    task automatic test_busy_ignore();
        int dones = 0;
        logic [QW-1:0] eq;
        logic          ez;
        model(50, 5, eq, ez);
        @(posedge CLK); #1;
        dividend = DW'(50); dividor = DVW'(5); division_start = 1'b1;
        for (int c = 1; c <= 2 * LAT; c++) begin
            @(posedge CLK); #1;
            if (c == 1) division_start = 1'b0;
            if (c == 4) begin
                dividend = DW'(9); dividor = DVW'(3); division_start = 1'b1;
            end
            if (c == 5) division_start = 1'b0;
            if (division_done === 1'b1) dones++;
            n_checks++;
            if (division_done !== (c == LAT)) begin
                n_errors++;
                $display("[TB] FAIL busy_ignore done cycle %0d: got %b expected %b", c, division_done, (c == LAT));
            end
            if (c == LAT) begin
                n_checks++;
                if (signed_division !== eq) begin
                    n_errors++;
                    $display("[TB] FAIL busy_ignore quotient: got %h expected %h", signed_division, eq);
                end
            end
        end
        n_checks++;
        if (dones != 1) begin
            n_errors++;
            $display("[TB] FAIL busy_ignore done_count: got %0d expected 1", dones);
        end
        prev_q = eq;
        prev_z = ez;
    endtask

    // Start held high: second operation begins on the idle cycle after done.
    task automatic test_back_to_back();
        logic [QW-1:0] q1;
        logic [QW-1:0] q2;
        logic          z1;
        logic          z2;
        logic [QW-1:0] want_q;
        model(100, 7, q1, z1);
        model(20, 4, q2, z2);
        @(posedge CLK); #1;
        dividend = DW'(100); dividor = DVW'(7); division_start = 1'b1;
        for (int c = 1; c <= 2 * LAT + 3; c++) begin
            @(posedge CLK); #1;
            if (c == 1) begin
                dividend = DW'(20); dividor = DVW'(4);
            end
            if (c == 2 * LAT + 1) division_start = 1'b0;
            n_checks++;
            if (div_busy !== ((c < LAT) || (c > LAT + 1 && c < 2 * LAT + 1))) begin
                n_errors++;
                $display("[TB] FAIL b2b busy cycle %0d: got %b", c, div_busy);
            end
            n_checks++;
            if (division_done !== (c == LAT || c == 2 * LAT + 1)) begin
                n_errors++;
                $display("[TB] FAIL b2b done cycle %0d: got %b", c, division_done);
            end
            if (c == LAT || c == 2 * LAT + 1) begin
                want_q = (c == LAT) ? q1 : q2;
                n_checks++;
                if (signed_division !== want_q) begin
                    n_errors++;
                    $display("[TB] FAIL b2b quotient cycle %0d: got %h expected %h", c, signed_division, want_q);
                end
            end
        end
        prev_q = q2;
        prev_z = z2;
    endtask

    // Reset during the iteration aborts it: outputs clear, no done appears.
    task automatic test_reset_mid();
        @(posedge CLK); #1;
        dividend = DW'(100); dividor = DVW'(7); division_start = 1'b1;
        for (int c = 1; c <= LAT + 6; c++) begin
            @(posedge CLK); #1;
            if (c == 1) division_start = 1'b0;
            if (c == 6) RST = 1'b1;
            if (c == 7) RST = 1'b0;
            if (c >= 7) begin
                n_checks++;
                if ({signed_division, division_done, div_busy, div_zero} !== '0) begin
                    n_errors++;
                    $display("[TB] FAIL reset_mid cycle %0d: got q=%h done=%b busy=%b zero=%b expected all zero", c, signed_division, division_done, div_busy, div_zero);
                end
            end else begin
                n_checks++;
                if (div_busy !== 1'b1) begin
                    n_errors++;
                    $display("[TB] FAIL reset_mid busy cycle %0d: got %b expected 1", c, div_busy);
                end
            end
        end
        prev_q = '0;
        prev_z = 1'b0;
        run_div(20, 4, "after_reset");
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_basic();
        test_signs();
        test_saturation();
        test_div_zero();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
